// File: rtl/reg_arb_pkg.sv
// Shared types and default sizing for the register read arbiter.
// Zero-register handling in the top is selected by the REG_ZERO_EN macro.
package reg_arb_pkg;

  localparam int WORD_LENGTH_DEF = 32;
  localparam int SIZE_DEF        = 5;
  localparam int N_REQ_DEF       = 4;
  localparam int MAX_REQ         = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    RESP = 2'd2
  } state_t;

  // One-hot of an index, sized for the largest supported requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    logic [MAX_REQ-1:0] v;
    v = '0;
    v[idx[2:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_read_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting index at or above ptr,
// wrapping around, plus a flag that any request is present.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  int unsigned idx;

  // Walk offsets from farthest to nearest so the closest requester wins last.
  always_comb begin
    winner  = '0;
    idx     = 0;
    any_req = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx[IDX_W-1:0]]) winner = idx[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/reg_read_arbiter.sv
// Round-robin arbiter sharing one register-file read mux among N_REQ readers.
// Define REG_ZERO_EN to force reads of address 0 to return all-zeros.
module reg_read_arbiter
  import reg_arb_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int SIZE        = SIZE_DEF,
  parameter int N_REQ       = N_REQ_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*SIZE-1:0] addr_flat,
  output logic [SIZE-1:0]       sel_out,
  input  logic [WORD_LENGTH-1:0] mux_data,
  output logic [N_REQ-1:0]      grant,
  output logic [WORD_LENGTH-1:0] rd_data,
  output logic [N_REQ-1:0]      rd_valid,
  output logic                  busy
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t                 state_q;
  logic [IDX_W-1:0]       ptr_q, win_q, ptr_d, pick_idx;
  logic                   pick_any;
  logic [SIZE-1:0]        addr_q, pick_addr;
  logic [N_REQ-1:0]       grant_q, rd_valid_q, pick_oh, win_oh;
  logic [WORD_LENGTH-1:0] rd_data_q, capture_d;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (pick_idx),
    .any_req (pick_any)
  );

  always_comb begin
    pick_addr = addr_flat[int'(pick_idx)*SIZE +: SIZE];
    pick_oh   = N_REQ'(onehot(32'(pick_idx)));
    win_oh    = N_REQ'(onehot(32'(win_q)));
    ptr_d     = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
`ifdef REG_ZERO_EN
    capture_d = (addr_q == '0) ? '0 : mux_data;
`else
    capture_d = mux_data;
`endif
  end

  // Winner and address are latched at arbitration so later input changes
  // cannot disturb the transaction already in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      addr_q     <= '0;
      grant_q    <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q <= SEL;
            win_q   <= pick_idx;
            addr_q  <= pick_addr;
            ptr_q   <= ptr_d;
            grant_q <= pick_oh;
          end
        end
        SEL: begin
          state_q    <= RESP;
          rd_data_q  <= capture_d;
          rd_valid_q <= win_oh;
        end
        RESP: begin
          state_q    <= IDLE;
          addr_q     <= '0;
          grant_q    <= '0;
          rd_valid_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel_out  = addr_q;
  assign grant    = grant_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_reg_read_arbiter.sv
// Directed bench for reg_read_arbiter with a transaction-level reference model.
module tb_reg_read_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [19:0] addr_flat;
  logic [4:0]  sel_out;
  logic [31:0] mux_data;
  logic [3:0]  grant;
  logic [31:0] rd_data;
  logic [3:0]  rd_valid;
  logic        busy;

  int tests = 0;
  int fails = 0;
  bit done  = 0;

  reg_read_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .addr_flat (addr_flat),
    .sel_out   (sel_out),
    .mux_data  (mux_data),
    .grant     (grant),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Register file stand-in: address 0 reads all-ones, others a tagged word.
  function automatic logic [31:0] mux_word(input logic [4:0] s);
    if (s == 5'd0) return 32'hFFFF_FFFF;
    return 32'hA5A5_0000 | {27'd0, s};
  endfunction

  function automatic logic [31:0] read_result(input logic [4:0] s);
`ifdef REG_ZERO_EN
    if (s == 5'd0) return 32'h0;
`endif
    return mux_word(s);
  endfunction

  // First requester found searching upward from p with wrap.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return 0;
  endfunction

  assign mux_data = mux_word(sel_out);

  // Reference model: m_age counts cycles into the current transaction.
  int          m_age, m_ptr, m_win, m_pick;
  logic [4:0]  m_addr;
  logic [31:0] m_rdata;
  int          win_log[$];

  assign m_pick = rr_pick(req, m_ptr);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_age   <= 0;
      m_ptr   <= 0;
      m_win   <= 0;
      m_addr  <= '0;
      m_rdata <= '0;
    end else if (m_age == 0) begin
      if (req != 4'd0) begin
        m_age  <= 1;
        m_win  <= m_pick;
        m_addr <= addr_flat[m_pick*5 +: 5];
        m_ptr  <= (m_pick + 1) % 4;
        win_log.push_back(m_pick);
      end
    end else if (m_age == 1) begin
      m_age   <= 2;
      m_rdata <= read_result(m_addr);
    end else begin
      m_age <= 0;
    end
  end

  logic [3:0] exp_grant, exp_valid;
  logic [4:0] exp_sel;
  assign exp_grant = (m_age != 0) ? 4'(1 << m_win) : 4'd0;
  assign exp_valid = (m_age == 2) ? 4'(1 << m_win) : 4'd0;
  assign exp_sel   = (m_age != 0) ? m_addr : 5'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    while (!done) begin
      @(negedge clk);
      chk("grant",    32'(grant),    32'(exp_grant));
      chk("sel_out",  32'(sel_out),  32'(exp_sel));
      chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
      chk("rd_data",  rd_data,       m_rdata);
      chk("busy",     32'(busy),     32'(m_age != 0));
      if (exp_valid != 4'd0)
        $display("[TB] read: requester %0d addr %0d data %h", m_win, m_addr, rd_data);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stimulus();
    int base;
    reset = 0; req = '0; addr_flat = '0;
    repeat (3) tick();
    reset = 1;
    tick();
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_rd_data", rd_data, 32'h0);

    // Single read from requester 0 at address 5.
    addr_flat[0 +: 5] = 5'd5; req = 4'b0001;
    tick();
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_sel", 32'(sel_out), 32'd5);
    req = 4'b0000;
    tick();
    chk("single_valid", 32'(rd_valid), 32'h1);
    chk("single_data", rd_data, 32'hA5A5_0005);
    tick();
    chk("single_idle_grant", 32'(grant), 32'h0);

    // Requester 2 drops its request while in SEL.
    addr_flat[10 +: 5] = 5'd9; req = 4'b0100;
    tick();
    chk("drop_grant", 32'(grant), 32'h4);
    req = 4'b0000;
    tick();
    chk("drop_valid", 32'(rd_valid), 32'h4);
    chk("drop_data", rd_data, 32'hA5A5_0009);
    tick();
    tick();
    chk("drop_no_regrant", 32'(grant), 32'h0);
    chk("drop_idle_busy", 32'(busy), 32'h0);

    // Fresh reset so contention starts from pointer 0.
    #2 reset = 0;
    #2 reset = 1;
    tick();

    // Full contention for 12 transactions.
    for (int i = 0; i < 4; i++) addr_flat[i*5 +: 5] = 5'(16 + 3*i);
    base = win_log.size();
    req = 4'b1111;
    repeat (36) tick();
    req = 4'b0000;
    repeat (3) tick();
    chk("contend_count", 32'(win_log.size() - base), 32'd12);
    for (int k = 0; k < 12; k++) begin
      if (base + k < win_log.size())
        chk("contend_order", 32'(win_log[base + k]), 32'(k % 4));
    end

    // Reset in the middle of SEL discards the transaction.
    addr_flat[0 +: 5] = 5'd7; req = 4'b0001;
    tick();
    chk("midrst_pre_grant", 32'(grant), 32'h1);
    #2 reset = 0;
    #1;
    chk("midrst_grant", 32'(grant), 32'h0);
    chk("midrst_sel", 32'(sel_out), 32'h0);
    chk("midrst_valid", 32'(rd_valid), 32'h0);
    chk("midrst_data", rd_data, 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    req = 4'b0000;
    tick();
    reset = 1;
    addr_flat[5 +: 5] = 5'd11; req = 4'b1010;
    tick();
    chk("postrst_grant", 32'(grant), 32'h2);
    req = 4'b0000;
    tick();
    chk("postrst_data", rd_data, 32'hA5A5_000B);
    tick();

    // Address 0 read.
    addr_flat[0 +: 5] = 5'd0; req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
`ifdef REG_ZERO_EN
    chk("zero_reg_data", rd_data, 32'h0000_0000);
`else
    chk("zero_reg_data", rd_data, 32'hFFFF_FFFF);
`endif
    tick();
    tick();
    done = 1;
  endtask

  initial begin
    fork
      compare_loop();
      stimulus();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
